stream_frame_arbiter: RTL and testbench
=======================================

Name: stream_frame_arbiter

Overview:
- Frame-aware 2:1 arbiter for 12-bit packed RGB pixel streams (sop/eop/valid/ready) feeding the pixel expander stage.
- Selects between source 0 (camera) and source 1 (test pattern) and switches only on frame boundaries, so the downstream stage never sees a spliced frame.
- Counts pixels per frame, flags malformed frames and counts completed frames for the status registers.

Parameters:
- DATA_WIDTH, 12, pixel word width on both inputs and the output.
- FRAME_PIXELS, 76800, expected accepted beats per frame, sop and eop beats included (320x240).
- CNT_W, 17, width of the pixel counter; must satisfy 2^CNT_W > FRAME_PIXELS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- src_sel  in  1  requested source (0 = s0, 1 = s1); honoured only between frames.
- s0_data  in  DATA_WIDTH  source 0 pixel.
- s0_sop / s0_eop / s0_valid  in  1 each  source 0 framing and valid.
- s0_ready  out  1  source 0 ready.
- s1_data  in  DATA_WIDTH  source 1 pixel.
- s1_sop / s1_eop / s1_valid  in  1 each  source 1 framing and valid.
- s1_ready  out  1  source 1 ready.
- data_out  out  DATA_WIDTH  forwarded pixel.
- sop_out / eop_out / valid_out  out  1 each  forwarded framing and valid.
- ready_in  in  1  downstream ready.
- active_src  out  1  currently granted source.
- frame_count  out  16  completed frames, wraps 0xFFFF -> 0.
- frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Handshake: a beat is accepted when the granted source's valid and ready are both 1. Zero latency: data_out, sop_out and eop_out are a combinational mux of the granted source.
- valid_out is forced to 0 whenever reset = 0.
- Reset (reset = 0 at a clock edge): state IDLE, active_src 0, pix_cnt 0, frame_count 0, frame_err 0. Reset takes priority over every other event, including mid-frame; the partial frame is abandoned and no error is flagged.
- FSM has two states, IDLE and STREAM.
- IDLE behaviour:
  - active_src <= src_sel every cycle, so a src_sel change takes effect one cycle later.
  - Granted source, sop = 0: ready = 1, valid_out = 0. Beat is discarded (drops the tail of a partially seen frame).
  - Granted source, sop = 1: valid_out = valid, ready = ready_in.
  - Accepted sop beat: pix_cnt <= 1 and state goes to STREAM.
  - Accepted beat with sop = 1 and eop = 1: counts as a complete 1-pixel frame. frame_count increments; frame_err pulses unless FRAME_PIXELS = 1; state stays IDLE.
- STREAM behaviour:
  - active_src is frozen; src_sel is ignored.
  - valid_out = granted valid; granted ready = ready_in.
  - Accepted beat with no sop and no eop: pix_cnt += 1, saturating at all-ones.
  - Accepted eop: frame_count += 1 and state goes to IDLE. frame_err pulses if pix_cnt + 1 != FRAME_PIXELS.
  - Accepted sop (mid-frame restart): forwarded; frame_err pulses; pix_cnt <= 1; stays STREAM (sop with eop behaves as in IDLE).
- Non-granted source: ready = 0 (back-pressured) in both states.
- frame_err is registered: it is high in the cycle after the offending acceptance, for exactly one cycle.

Optional Feature:
- Macro: STREAM_ARB_FLUSH_INACTIVE_EN.
- Defined: the non-granted source's ready is held at 1, and its beats are discarded, so a free-running camera never stalls while the test pattern is shown.
- Undefined: the non-granted source's ready = 0, as specified above.

Test Plan:
- Reset then src_sel = 0, s0 sends a 76800-beat frame with ready_in = 1 -> all beats forwarded with zero latency, frame_count = 1, frame_err never high, s1_ready = 0 throughout.
- src_sel toggles 0 -> 1 at beat 100 of an s0 frame -> rest of the s0 frame forwarded; active_src becomes 1 only after s0 eop is accepted; the next s1 sop is forwarded.
- IDLE with s0 presenting 5 beats with sop = 0 -> s0_ready = 1, valid_out = 0 for all 5; the following sop beat is forwarded and state goes to STREAM.
- s0 frame with eop at beat 1000 -> frame_err pulses for 1 cycle after eop acceptance, frame_count increments; second case, sop reasserted at beat 50 -> frame_err pulses, pix_cnt restarts at 1.
- ready_in randomly deasserted 50% during a frame -> no beat lost or duplicated, granted ready mirrors ready_in; reset = 0 at beat 300 -> next cycle state IDLE, frame_count 0, valid_out 0 while in reset.
- With STREAM_ARB_FLUSH_INACTIVE_EN defined and src_sel = 1, s0 streaming -> s0_ready = 1 constantly, no s0 data appears on data_out.

Source files
------------

// File: rtl/stream_frame_arbiter.sv
// Frame-aware 2:1 pixel stream arbiter: switches source only between frames, counts frames, flags malformed ones.
// Optional build macro STREAM_ARB_FLUSH_INACTIVE_EN: non-granted source is held ready and its beats dropped.
module stream_frame_arbiter #(
  parameter int DATA_WIDTH   = 12,
  parameter int FRAME_PIXELS = 76800,
  parameter int CNT_W        = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  src_sel,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s0_sop,
  input  logic                  s0_eop,
  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  s1_sop,
  input  logic                  s1_eop,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  sop_out,
  output logic                  eop_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  active_src,
  output logic [15:0]           frame_count,
  output logic                  frame_err
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [CNT_W:0] FRAME_PIX_C   = (CNT_W+1)'(FRAME_PIXELS);
  localparam logic           ONE_PIX_FRAME = (FRAME_PIXELS == 1);

`ifdef STREAM_ARB_FLUSH_INACTIVE_EN
  localparam logic OTHER_READY = 1'b1;
`else
  localparam logic OTHER_READY = 1'b0;
`endif

  state_t           state_q, state_d;
  logic             active_src_q, active_src_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [15:0]      frame_count_q, frame_count_d;
  logic             frame_err_q, frame_err_d;

  logic                  g_sop, g_eop, g_valid, g_ready, g_vout, accept;
  logic [DATA_WIDTH-1:0] g_data;

  always_comb begin
    g_data  = active_src_q ? s1_data  : s0_data;
    g_sop   = active_src_q ? s1_sop   : s0_sop;
    g_eop   = active_src_q ? s1_eop   : s0_eop;
    g_valid = active_src_q ? s1_valid : s0_valid;

    state_d       = state_q;
    active_src_d  = active_src_q;
    pix_cnt_d     = pix_cnt_q;
    frame_count_d = frame_count_q;
    frame_err_d   = 1'b0;
    g_ready       = ready_in;
    g_vout        = g_valid;
    accept        = 1'b0;

    case (state_q)
      IDLE: begin
        // Beats before a sop are the tail of a frame we joined late: swallow them.
        if (!g_sop) begin
          g_ready = 1'b1;
          g_vout  = 1'b0;
        end
        accept       = g_valid && g_ready;
        active_src_d = src_sel;
        if (accept && g_sop) begin
          if (g_eop) begin
            frame_count_d = frame_count_q + 16'd1;
            frame_err_d   = !ONE_PIX_FRAME;
          end else begin
            // Keep the grant that carried this sop so the frame is never spliced.
            active_src_d = active_src_q;
            pix_cnt_d    = CNT_W'(1);
            state_d      = STREAM;
          end
        end
      end
      STREAM: begin
        accept = g_valid && g_ready;
        if (accept) begin
          if (g_sop) begin
            if (g_eop) begin
              frame_count_d = frame_count_q + 16'd1;
              frame_err_d   = !ONE_PIX_FRAME;
              state_d       = IDLE;
            end else begin
              frame_err_d = 1'b1;
              pix_cnt_d   = CNT_W'(1);
            end
          end else if (g_eop) begin
            frame_count_d = frame_count_q + 16'd1;
            frame_err_d   = (({1'b0, pix_cnt_q} + (CNT_W+1)'(1)) != FRAME_PIX_C);
            state_d       = IDLE;
          end else if (pix_cnt_q != {CNT_W{1'b1}}) begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      active_src_q  <= 1'b0;
      pix_cnt_q     <= '0;
      frame_count_q <= '0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_src_q  <= active_src_d;
      pix_cnt_q     <= pix_cnt_d;
      frame_count_q <= frame_count_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign data_out    = g_data;
  assign sop_out     = g_sop;
  assign eop_out     = g_eop;
  assign valid_out   = g_vout && reset;
  assign s0_ready    = active_src_q ? OTHER_READY : g_ready;
  assign s1_ready    = active_src_q ? g_ready : OTHER_READY;
  assign active_src  = active_src_q;
  assign frame_count = frame_count_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_stream_frame_arbiter.sv
// Directed bench for stream_frame_arbiter, built with a 64-pixel frame so whole frames stay short.
module tb_stream_frame_arbiter;
  localparam int FP = 64;

`ifdef STREAM_ARB_FLUSH_INACTIVE_EN
  localparam logic OTHER_RDY = 1'b1;
`else
  localparam logic OTHER_RDY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, src_sel, ready_in;
  logic [11:0] s0_data, s1_data, data_out;
  logic        s0_sop, s0_eop, s0_valid, s0_ready;
  logic        s1_sop, s1_eop, s1_valid, s1_ready;
  logic        sop_out, eop_out, valid_out, active_src, frame_err;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_fc   = 0;

  stream_frame_arbiter #(.DATA_WIDTH(12), .FRAME_PIXELS(FP), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .src_sel(src_sel),
    .s0_data(s0_data), .s0_sop(s0_sop), .s0_eop(s0_eop), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_sop(s1_sop), .s1_eop(s1_eop), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .data_out(data_out), .sop_out(sop_out), .eop_out(eop_out), .valid_out(valid_out),
    .ready_in(ready_in), .active_src(active_src), .frame_count(frame_count), .frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // One cycle with the given source presenting a beat; outputs checked at the falling edge.
  task automatic beat(input logic src, input logic sop, input logic eop, input logic [11:0] d,
                      input logic rdy, input logic exp_vout, input logic exp_rdy, input logic exp_err);
    if (src) begin
      s1_sop = sop; s1_eop = eop; s1_data = d; s1_valid = 1'b1; s0_valid = 1'b0;
    end else begin
      s0_sop = sop; s0_eop = eop; s0_data = d; s0_valid = 1'b1; s1_valid = 1'b0;
    end
    ready_in = rdy;
    @(negedge clk);
    chk("valid_out", 32'(valid_out), 32'(exp_vout));
    chk("grant_ready", 32'(src ? s1_ready : s0_ready), 32'(exp_rdy));
    chk("other_ready", 32'(src ? s0_ready : s1_ready), 32'(OTHER_RDY));
    chk("active_src", 32'(active_src), 32'(src));
    chk("frame_err", 32'(frame_err), 32'(exp_err));
    if (exp_vout) begin
      chk("data_out", 32'(data_out), 32'(d));
      chk("sop_out", 32'(sop_out), 32'(sop));
      chk("eop_out", 32'(eop_out), 32'(eop));
    end
    next_edge();
  endtask

  // restart_at > 0 re-asserts sop at that beat; toggle_at >= 0 flips src_sel at that beat.
  task automatic send_frame(input logic src, input int n, input int restart_at, input bit rnd, input int toggle_at);
    int  i = 0;
    int  guard = 0;
    bit  pend = 1'b0;
    bit  r;
    bit  eop_err;
    while (i < n && guard < 4000) begin
      r = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
      if (i == toggle_at) src_sel = ~src;
      beat(src, (i == 0) || (i == restart_at), i == n - 1, 12'(i + 256 * int'(src)), r, 1'b1, r, pend);
      pend = 1'b0;
      if (r) begin
        if (restart_at > 0 && i == restart_at && i != n - 1) pend = 1'b1;
        i++;
      end
      guard++;
    end
    chk("frame_beats", 32'(i), 32'(n));
    eop_err = ((restart_at > 0) ? (n - restart_at) : n) != FP;
    exp_fc++;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    @(negedge clk);
    chk("eop_err", 32'(frame_err), 32'(eop_err));
    chk("frame_count", 32'(frame_count), 32'(exp_fc));
    chk("active_hold", 32'(active_src), 32'(src));
    next_edge();
    @(negedge clk);
    chk("err_one_cycle", 32'(frame_err), 32'd0);
    next_edge();
  endtask

  initial begin
    reset = 1'b0; src_sel = 1'b0; ready_in = 1'b1;
    s0_data = '0; s0_sop = 1'b0; s0_eop = 1'b0; s0_valid = 1'b0;
    s1_data = '0; s1_sop = 1'b0; s1_eop = 1'b0; s1_valid = 1'b0;
    next_edge();
    s0_valid = 1'b1; s0_sop = 1'b1; s0_data = 12'h5A5;
    @(negedge clk);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_active_src", 32'(active_src), 32'd0);
    next_edge();
    reset = 1'b1; s0_valid = 1'b0; s0_sop = 1'b0;
    next_edge();

    // Clean frames, then a source change requested mid-frame.
    send_frame(1'b0, FP, 0, 1'b0, -1);
    send_frame(1'b0, FP, 0, 1'b0, 10);
    @(negedge clk);
    chk("switch_after_eop", 32'(active_src), 32'd1);
    next_edge();
    send_frame(1'b1, FP, 0, 1'b0, -1);

    // Back to s0; tail beats without sop are swallowed even with downstream stalled.
    src_sel = 1'b0;
    next_edge();
    for (int k = 0; k < 5; k++) beat(1'b0, 1'b0, 1'b0, 12'(100 + k), 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(1'b0, FP, 0, 1'b0, -1);

    send_frame(1'b0, 20, 0, 1'b0, -1);
    send_frame(1'b0, FP + 10, 10, 1'b0, -1);
    send_frame(1'b0, 1, 0, 1'b0, -1);
    send_frame(1'b0, FP, 0, 1'b1, -1);

    // Reset in the middle of an s1 frame.
    src_sel = 1'b1;
    next_edge();
    for (int k = 0; k < 30; k++) beat(1'b1, k == 0, 1'b0, 12'(k), 1'b1, 1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    s1_valid = 1'b1; s1_sop = 1'b0; s1_eop = 1'b0;
    @(negedge clk);
    chk("valid_in_reset", 32'(valid_out), 32'd0);
    next_edge();
    @(negedge clk);
    chk("rst_mid_count", 32'(frame_count), 32'd0);
    chk("rst_mid_active", 32'(active_src), 32'd0);
    chk("rst_mid_err", 32'(frame_err), 32'd0);
    exp_fc = 0;
    next_edge();
    reset = 1'b1;
    next_edge();
    beat(1'b1, 1'b0, 1'b0, 12'h123, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(1'b1, FP, 0, 1'b0, -1);

    // Non-granted source streaming while s1 holds the grant.
    s1_valid = 1'b0;
    ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s0_valid = 1'b1; s0_sop = (k == 0); s0_eop = 1'b0; s0_data = 12'(k + 7);
      @(negedge clk);
      chk("inactive_ready", 32'(s0_ready), 32'(OTHER_RDY));
      chk("inactive_no_fwd", 32'(valid_out), 32'd0);
      next_edge();
    end
    s0_valid = 1'b0;
    @(negedge clk);
    chk("inactive_count", 32'(frame_count), 32'(exp_fc));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
